// File: rtl/argon_pkg.sv
// Shared Argon front-end definitions: fetch FSM encoding and the default
// address/instruction widths used across the core.
package argon_pkg;

    localparam int ARGON_ADDR_WIDTH  = 16;
    localparam int ARGON_INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/argon_fetch_queue_if.sv
// Fetch-queue bus bundle: memory read port (re/busy) plus decode valid/ready port.
interface argon_fetch_queue_if
    import argon_pkg::*;
#(
    parameter int ADDR_WIDTH  = ARGON_ADDR_WIDTH,
    parameter int INSTR_WIDTH = ARGON_INSTR_WIDTH,
    parameter int DEPTH       = 4
);

    localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0]  mem_address;
    logic                   mem_re;
    logic [INSTR_WIDTH-1:0] mem_data;
    logic                   mem_busy;

    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   instr_ready;
    logic [CNT_WIDTH-1:0]   count;

    modport master (
        output mem_address, mem_re, instr_valid, instr, instr_pc, count,
        input  mem_data, mem_busy, instr_ready
    );

    modport slave (
        input  mem_address, mem_re, instr_valid, instr, instr_pc, count,
        output mem_data, mem_busy, instr_ready
    );

endinterface

// File: rtl/argon_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr}; flush empties it in one cycle
// and takes priority over any same-cycle push or pop.
module argon_fifo
    import argon_pkg::*;
#(
    parameter int ADDR_WIDTH  = ARGON_ADDR_WIDTH,
    parameter int INSTR_WIDTH = ARGON_INSTR_WIDTH,
    parameter int DEPTH       = 4,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_push,
    input  logic [ADDR_WIDTH-1:0]  i_push_pc,
    input  logic [INSTR_WIDTH-1:0] i_push_instr,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic                   o_head_valid,
    output logic [ADDR_WIDTH-1:0]  o_head_pc,
    output logic [INSTR_WIDTH-1:0] o_head_instr,
    output logic [CNT_W-1:0]       o_count
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             write_en;

    assign write_en = i_push & ~i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observed once count covers it.
    always_ff @(posedge i_clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= {i_push_pc, i_push_instr};
        end
    end

    assign o_head_valid = (count_q != '0);
    assign o_head_pc    = mem_q[rd_ptr_q].pc;
    assign o_head_instr = mem_q[rd_ptr_q].instr;
    assign o_count      = count_q;

endmodule

// File: rtl/argon_fetch_queue.sv
// Decoupled Argon instruction prefetcher: issues sequential reads, queues
// {pc, instr} and presents them to decode; supports redirect and halt.
module argon_fetch_queue
    import argon_pkg::*;
#(
    parameter int ADDR_WIDTH                  = ARGON_ADDR_WIDTH,
    parameter int INSTR_WIDTH                 = ARGON_INSTR_WIDTH,
    parameter int DEPTH                       = 4,
    parameter logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(1),
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_halt,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    argon_fetch_queue_if.master   fq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_re_q, mem_re_d;

    logic                   complete;
    logic                   push;
    logic                   pop;
    logic                   space;
    logic                   issue_ok;
    logic [ADDR_WIDTH-1:0]  seq_pc;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;
    logic                   head_valid;
    logic [ADDR_WIDTH-1:0]  head_pc;
    logic [INSTR_WIDTH-1:0] head_instr;

    // Slot reservation: a read may only be issued if the queue will still have
    // room after this cycle, so the returning data can never overflow it.
    always_comb begin
        complete   = mem_re_q & ~fq.mem_busy;
        push       = complete & (state_q == REQ) & ~i_redirect;
        pop        = head_valid & fq.instr_ready;
        count_next = i_redirect ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
        space      = (count_next < CNT_W'(DEPTH));
        issue_ok   = ~i_halt & space;
        seq_pc     = fetch_pc_q + PC_STEP;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_re_q   <= mem_re_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue_ok && !i_redirect) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (i_redirect) begin
                    state_d = fq.mem_busy ? DRAIN : IDLE;
                end else if (complete && !issue_ok) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!fq.mem_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A read held in DRAIN belongs to the old stream; only fetch_pc follows
    // the redirect while the memory finishes it.
    always_comb begin
        fetch_pc_d = i_redirect ? i_redirect_pc : fetch_pc_q;
        mem_re_d   = mem_re_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                mem_re_d = 1'b0;
                if (issue_ok && !i_redirect) begin
                    mem_re_d   = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (i_redirect) begin
                    if (!fq.mem_busy) begin
                        mem_re_d = 1'b0;
                    end
                end else if (complete) begin
                    fetch_pc_d = seq_pc;
                    if (issue_ok) begin
                        mem_addr_d = seq_pc;
                    end else begin
                        mem_re_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (!fq.mem_busy) begin
                    mem_re_d = 1'b0;
                end
            end
            default: mem_re_d = 1'b0;
        endcase
    end

    argon_fifo #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .DEPTH       (DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_push       (push),
        .i_push_pc    (fetch_pc_q),
        .i_push_instr (fq.mem_data),
        .i_pop        (pop),
        .i_flush      (i_redirect),
        .o_head_valid (head_valid),
        .o_head_pc    (head_pc),
        .o_head_instr (head_instr),
        .o_count      (count)
    );

    assign fq.mem_re      = mem_re_q;
    assign fq.mem_address = mem_addr_q;
    assign fq.instr_valid = head_valid;
    assign fq.instr       = head_instr;
    assign fq.instr_pc    = head_pc;
    assign fq.count       = count;

endmodule

// File: tb/tb_argon_fetch_queue.sv
// Directed bench for argon_fetch_queue with a scoreboard of expected head PCs.
module tb_argon_fetch_queue;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_halt;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;

    int checks = 0;
    int bad    = 0;

    logic [15:0] exp_q [$];
    logic        drain = 1'b0;

    argon_fetch_queue_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(32), .DEPTH(4)) fq ();

    argon_fetch_queue #(
        .ADDR_WIDTH  (16),
        .INSTR_WIDTH (32),
        .DEPTH       (4),
        .PC_STEP     (16'd1),
        .RESET_PC    (16'h0000)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_halt        (i_halt),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .fq            (fq)
    );

    always #5 i_clk = ~i_clk;

    // Memory model: each word encodes its own address.
    assign fq.mem_data = {~fq.mem_address, fq.mem_address};

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic halt, input logic redirect, input logic [15:0] rpc,
                                 input logic busy, input logic ready);
        i_halt         = halt;
        i_redirect     = redirect;
        i_redirect_pc  = rpc;
        fq.mem_busy    = busy;
        fq.instr_ready = ready;
    endtask

    // Scoreboard step, taken mid-cycle: check occupancy and any pop, then
    // account for the flush or completion that the coming edge will perform.
    task automatic scoreboardStep();
        logic [15:0] pc;
        if (!i_reset_n) begin
            exp_q.delete();
            drain = 1'b0;
        end else begin
            checkOutput("count", 64'(fq.count), 64'(exp_q.size()));
            checkOutput("valid", 64'(fq.instr_valid), 64'(exp_q.size() != 0));
            if (fq.instr_valid && fq.instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    bad++;
                    $error("[TB] FAIL pop_empty observed=pop expected=none");
                end else begin
                    pc = exp_q.pop_front();
                    checkOutput("pop_pc", 64'(fq.instr_pc), 64'(pc));
                    checkOutput("pop_instr", 64'(fq.instr), 64'({~pc, pc}));
                end
            end
            if (i_redirect) begin
                exp_q.delete();
                drain = fq.mem_re & fq.mem_busy;
            end else if (fq.mem_re && !fq.mem_busy) begin
                if (!drain) exp_q.push_back(fq.mem_address);
                drain = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        scoreboardStep();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkMem(input string tag, input logic re, input logic [15:0] addr);
        checkOutput({tag, "_re"}, 64'(fq.mem_re), 64'(re));
        if (re) checkOutput({tag, "_addr"}, 64'(fq.mem_address), 64'(addr));
    endtask

    initial begin
        i_reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        @(posedge i_clk);
        #1;
        checkOutput("rst_re", 64'(fq.mem_re), 64'd0);
        checkOutput("rst_addr", 64'(fq.mem_address), 64'd0);
        checkOutput("rst_valid", 64'(fq.instr_valid), 64'd0);
        checkOutput("rst_count", 64'(fq.count), 64'd0);
        i_reset_n = 1'b1;

        // Back-to-back sequential fetch from RESET_PC.
        tick();
        checkMem("e1", 1'b1, 16'h0000);
        checkOutput("e1_valid", 64'(fq.instr_valid), 64'd0);
        tick();
        checkMem("e2", 1'b1, 16'h0001);
        checkOutput("e2_pc", 64'(fq.instr_pc), 64'h0000);
        for (int e = 3; e <= 7; e++) begin
            tick();
            checkMem("stream", 1'b1, 16'(e - 1));
            checkOutput("stream_pc", 64'(fq.instr_pc), 64'(e - 2));
        end

        // Decode stalls: queue fills to DEPTH and issuing stops.
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (6) tick();
        checkOutput("full_count", 64'(fq.count), 64'd4);
        checkOutput("full_re", 64'(fq.mem_re), 64'd0);
        checkOutput("full_pc", 64'(fq.instr_pc), 64'h0005);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        checkMem("refill", 1'b1, 16'h0009);
        checkOutput("refill_count", 64'(fq.count), 64'd3);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        checkOutput("refull_re", 64'(fq.mem_re), 64'd0);
        checkOutput("refull_count", 64'(fq.count), 64'd4);

        // Redirect to 0x0005, then memory stalls that read for three cycles.
        applyStimulus(1'b0, 1'b1, 16'h0005, 1'b0, 1'b1);
        tick();
        checkOutput("redir_count", 64'(fq.count), 64'd0);
        checkOutput("redir_re", 64'(fq.mem_re), 64'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            checkMem("busy_hold", 1'b1, 16'h0005);
            checkOutput("busy_count", 64'(fq.count), 64'd0);
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        checkMem("busy_done", 1'b1, 16'h0006);
        checkOutput("busy_pc", 64'(fq.instr_pc), 64'h0005);
        tick();
        checkMem("to7", 1'b1, 16'h0007);

        // Redirect to 0x0100 while the read at 0x0007 is stalled.
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 16'h0100, 1'b1, 1'b1);
        tick();
        checkMem("drain", 1'b1, 16'h0007);
        checkOutput("drain_count", 64'(fq.count), 64'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        tick();
        checkMem("drain_hold", 1'b1, 16'h0007);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        checkOutput("drain_end_re", 64'(fq.mem_re), 64'd0);
        tick();
        checkMem("new_stream", 1'b1, 16'h0100);
        tick();
        checkOutput("new_pc", 64'(fq.instr_pc), 64'h0100);

        // Address wrap past 0xFFFF.
        applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1);
        tick();
        checkOutput("wrap_redir_re", 64'(fq.mem_re), 64'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        checkMem("wrap0", 1'b1, 16'hFFFE);
        tick();
        checkMem("wrap1", 1'b1, 16'hFFFF);
        tick();
        checkMem("wrap2", 1'b1, 16'h0000);
        checkOutput("wrap2_pc", 64'(fq.instr_pc), 64'hFFFF);
        tick();
        checkMem("wrap3", 1'b1, 16'h0001);

        // Halt: in-flight read at 0x0001 completes, nothing new issued.
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        tick();
        checkMem("halt_hold", 1'b1, 16'h0001);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        checkOutput("halt_re", 64'(fq.mem_re), 64'd0);
        checkOutput("halt_pc", 64'(fq.instr_pc), 64'h0001);
        repeat (3) tick();
        checkOutput("halt_idle_re", 64'(fq.mem_re), 64'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        checkMem("resume", 1'b1, 16'h0002);

        // Asynchronous reset in the middle of a stalled read.
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        tick();
        #2;
        i_reset_n = 1'b0;
        #1;
        checkOutput("arst_re", 64'(fq.mem_re), 64'd0);
        checkOutput("arst_addr", 64'(fq.mem_address), 64'd0);
        checkOutput("arst_valid", 64'(fq.instr_valid), 64'd0);
        checkOutput("arst_count", 64'(fq.count), 64'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        i_reset_n = 1'b1;
        tick();
        checkMem("rerun", 1'b1, 16'h0000);
        tick();
        checkOutput("rerun_pc", 64'(fq.instr_pc), 64'h0000);
        tick();

        $display("[TB] directed sequence complete");
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
